// File: rtl/pc_pkg.sv
// Shared constants for the fetch-path PC unit: default text base, fault cause codes and FSM states.
package pc_pkg;

  localparam logic [31:0] DEFAULT_TEXT_BASE  = 32'h0040_0000;
  localparam int unsigned DEFAULT_TEXT_WORDS = 1024;

  localparam logic [1:0] PC_CAUSE_NONE     = 2'b00;
  localparam logic [1:0] PC_CAUSE_RANGE    = 2'b01;
  localparam logic [1:0] PC_CAUSE_MISALIGN = 2'b10;

  typedef logic [0:0] pc_state_t;
  localparam pc_state_t PC_RUN   = 1'b0;
  localparam pc_state_t PC_FAULT = 1'b1;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and status bundle between the core and the PC fetch unit.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              fault_clear_i;
  logic [31:0]       pc_o;
  logic [ADDR_W-1:0] phys_pc_o;
  logic              pc_valid_o;
  logic              fault_o;
  logic [1:0]        fault_cause_o;
  logic [31:0]       fault_pc_o;
  logic [31:0]       fetch_count_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, fault_clear_i,
    input  pc_o, phys_pc_o, pc_valid_o, fault_o, fault_cause_o, fault_pc_o, fetch_count_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, fault_clear_i,
    output pc_o, phys_pc_o, pc_valid_o, fault_o, fault_cause_o, fault_pc_o, fetch_count_o
  );
endinterface

// File: rtl/pc_range_check.sv
// Combinational segment decoder: virtual PC to word index, valid flag and fault cause.
// Misaligned detection is enabled by defining PC_MISALIGN_CHECK_EN.
module pc_range_check import pc_pkg::*; #(
  parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
  parameter int unsigned TEXT_WORDS = DEFAULT_TEXT_WORDS,
  parameter int unsigned ADDR_W     = $clog2(TEXT_WORDS)
) (
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] physPc,
  output logic              valid,
  output logic [1:0]        cause
);

  // 33-bit bounds so a segment ending at the top of the address space does not wrap.
  localparam logic [32:0] LoBound = {1'b0, TEXT_BASE};
  localparam logic [32:0] HiBound = {1'b0, TEXT_BASE} + (33'(TEXT_WORDS) << 2) - 33'd1;

  logic outOfRange;
  logic misaligned;

  assign physPc     = ADDR_W'((pc - TEXT_BASE) >> 2);
  assign outOfRange = ({1'b0, pc} < LoBound) || ({1'b0, pc} > HiBound);

`ifdef PC_MISALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    cause = PC_CAUSE_NONE;
    if (misaligned) begin
      cause = PC_CAUSE_MISALIGN;
    end else if (outOfRange) begin
      cause = PC_CAUSE_RANGE;
    end
  end

  assign valid = !misaligned && !outOfRange;

endmodule

// File: rtl/pc_fetch_unit.sv
// Registered program counter with stall/redirect, segment checking and a sticky fetch fault.
// Optional misaligned-PC check: define PC_MISALIGN_CHECK_EN.
module pc_fetch_unit import pc_pkg::*; #(
  parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
  parameter int unsigned TEXT_WORDS = DEFAULT_TEXT_WORDS,
  parameter int unsigned ADDR_W     = $clog2(TEXT_WORDS)
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_unit_if.slave bus
);

  pc_state_t         stateQ, stateD;
  logic [31:0]       pcQ, pcD;
  logic [31:0]       faultPcQ, faultPcD;
  logic [31:0]       fetchCountQ, fetchCountD;
  logic [1:0]        causeQ, causeD;
  logic [ADDR_W-1:0] physPc;
  logic              pcValid;
  logic [1:0]        checkCause;

  pc_range_check #(
    .TEXT_BASE (TEXT_BASE),
    .TEXT_WORDS(TEXT_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_range (
    .pc    (pcQ),
    .physPc(physPc),
    .valid (pcValid),
    .cause (checkCause)
  );

  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    faultPcD    = faultPcQ;
    fetchCountD = fetchCountQ;
    causeD      = causeQ;
    case (stateQ)
      PC_RUN: begin
        // An invalid PC wins over everything so the faulting address is never lost.
        if (!pcValid) begin
          stateD   = PC_FAULT;
          faultPcD = pcQ;
          causeD   = checkCause;
        end else begin
          if (bus.redirect_i || !bus.stall_i) begin
            fetchCountD = fetchCountQ + 32'd1;
          end
          if (bus.redirect_i) begin
            pcD = bus.redirect_pc_i;
          end else if (!bus.stall_i) begin
            pcD = pcQ + 32'd4;
          end
        end
      end
      PC_FAULT: begin
        if (bus.fault_clear_i) begin
          stateD = PC_RUN;
          causeD = PC_CAUSE_NONE;
          pcD    = bus.redirect_i ? bus.redirect_pc_i : TEXT_BASE;
        end
      end
      default: stateD = PC_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= PC_RUN;
      pcQ         <= TEXT_BASE;
      faultPcQ    <= 32'd0;
      fetchCountQ <= 32'd0;
      causeQ      <= PC_CAUSE_NONE;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      faultPcQ    <= faultPcD;
      fetchCountQ <= fetchCountD;
      causeQ      <= causeD;
    end
  end

  assign bus.pc_o          = pcQ;
  assign bus.phys_pc_o     = physPc;
  assign bus.pc_valid_o    = pcValid;
  assign bus.fault_o       = (stateQ == PC_FAULT);
  assign bus.fault_cause_o = causeQ;
  assign bus.fault_pc_o    = faultPcQ;
  assign bus.fetch_count_o = fetchCountQ;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Registered program-counter unit for the MIPS32 SOC fetch path. It holds the virtual PC and advances, stalls or redirects it. It decodes the PC into a word index for the instruction memory and checks it against a parametrised text segment. It latches a sticky fetch fault with its cause and address, and freezes fetch until software or the core clears the fault.

## Interface
- TEXT_BASE, 32'h00400000, virtual byte address of text-segment word 0; must be 4-byte aligned.
- TEXT_WORDS, 1024, number of 32-bit words in instruction memory; power of two.
- ADDR_W, $clog2(TEXT_WORDS), width of the physical word index.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold PC this cycle.
- redirect_i  in  1  load redirect_pc_i (branch/jump/exception vector).
- redirect_pc_i  in  32  redirect target, virtual byte address.
- fault_clear_i  in  1  leave FAULT state.
- pc_o  out  32  current virtual PC (register).
- phys_pc_o  out  ADDR_W  (pc_o - TEXT_BASE) >> 2, truncated to ADDR_W bits.
- pc_valid_o  out  1  current PC is inside the segment and passes all enabled checks.
- fault_o  out  1  sticky fault flag; high in FAULT state.
- fault_cause_o  out  2  2'b00 none, 2'b01 out of range, 2'b10 misaligned; 2'b11 reserved.
- fault_pc_o  out  32  PC that caused the fault.
- fetch_count_o  out  32  number of cycles in which a valid PC advanced or was redirected.

## Operation
- States: RUN and FAULT. Reset value is RUN.
- Reset values: pc_o = TEXT_BASE, fault_o = 0, fault_cause_o = 0, fault_pc_o = 0, fetch_count_o = 0. phys_pc_o = 0 and pc_valid_o = 1 follow from pc_o.
- Range check: the PC is out of range when pc_o < TEXT_BASE or pc_o > TEXT_BASE + 4*TEXT_WORDS - 1. Compare in 33-bit arithmetic so the upper bound does not wrap at 32'hFFFFFFFF.
- Misaligned check (only when the macro is defined): pc_o[1:0] != 0. Misaligned takes priority over out of range in fault_cause_o.
- RUN priority, highest first:
  - PC invalid: go to FAULT, latch fault_pc_o = pc_o and the cause, hold the PC. Redirect and stall are ignored.
  - redirect_i: pc <= redirect_pc_i. Redirect overrides stall.
  - stall_i: hold the PC.
  - Otherwise: pc <= pc + 4. The add wraps mod 2^32, and the range check catches the result.
- fetch_count_o increments on every RUN cycle with a valid PC and no stall, or with redirect_i asserted. It wraps mod 2^32.
- FAULT:
  - The PC is frozen and stall/redirect alone have no effect.
  - On fault_clear_i: go to RUN, clear fault_o and fault_cause_o, and keep fault_pc_o. pc <= redirect_pc_i if redirect_i is high in the same cycle, else pc <= TEXT_BASE.
- fault_clear_i in RUN is ignored.

## Timing
- pc_o, fault_*, and fetch_count_o are registered.
- phys_pc_o and pc_valid_o are combinational from the pc register, valid in the same cycle as pc_o.
- Redirect, stall, and increment take effect at the next edge (1-cycle latency).
- fault_o rises one edge after an invalid pc_o first appears. In that cycle pc_valid_o is already 0, which lets fetch suppress the memory access.
- Clearing takes one cycle. The new PC is visible the cycle after fault_clear_i is sampled.
- Reset asserted mid-fault or mid-redirect forces reset values immediately, regardless of clk.

## Configuration
- PC_MISALIGN_CHECK_EN defined: the misaligned check is active. PCs with pc[1:0] != 0 fault with cause 2'b10.
- PC_MISALIGN_CHECK_EN undefined: pc[1:0] are ignored, the word index is truncated, and only the range check can fault. Cause 2'b10 is never produced.

## Structure
- Package pc_pkg: TEXT_BASE default, cause codes (PC_CAUSE_NONE, PC_CAUSE_RANGE, PC_CAUSE_MISALIGN), and the state enum (PC_RUN, PC_FAULT).
- Sub-module pc_range_check: purely combinational. It maps the PC to phys_pc, a valid flag, and a cause. It is parametrised by TEXT_BASE, TEXT_WORDS, and ADDR_W, and is reusable for data-segment decoding.

## Test plan
- Reset: rst_n low, then high. Required: pc_o = 32'h00400000, phys_pc_o = 0, pc_valid_o = 1, fault_o = 0, fetch_count_o = 0.
- Run three cycles, then stall two cycles. Required: pc_o = 32'h0040000C, phys_pc_o = 3, held through the stall, fetch_count_o = 3.
- Redirect to 32'h00400FFC, then one increment.
  - Required: pc_o = 32'h00401000, pc_valid_o = 0.
  - Next edge: fault_o = 1, fault_cause_o = 2'b01, fault_pc_o = 32'h00401000.
  - PC frozen through later redirects.
- fault_clear_i alone. Required: pc_o = 32'h00400000 and fault_o = 0 next cycle. With redirect_i and target 32'h00400100, pc_o = 32'h00400100 and phys_pc_o = 64.
- With PC_MISALIGN_CHECK_EN defined, redirect to 32'h00400002. Required: fault with cause 2'b10. With the macro undefined, the PC is valid with phys_pc_o = 0 and no fault.
- Assert rst_n low while in FAULT. Required: immediate return to RUN, pc_o = 32'h00400000, all fault outputs 0.
